// File: rtl/noc_vc_credit_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_vc_credit_buffer_pkg
// Purpose  : Shared NoC parameters, VC-tagged flit type and VC id width helper
//            for the virtual-channel credit buffer and its arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package noc_vc_credit_buffer_pkg;

    localparam int Noc_VC_Channel = 2;
    localparam int Noc_Data_Width = 32;
    localparam int Noc_VC_Width   = (Noc_VC_Channel > 1) ? $clog2(Noc_VC_Channel) : 1;

    // A single-VC configuration still needs a 1-bit id field.
    function automatic int noc_vc_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    typedef struct packed {
        logic [Noc_VC_Width-1:0]   vc;
        logic [Noc_Data_Width-1:0] flit;
    } noc_vc_flit_t;

endpackage
`default_nettype wire

// File: rtl/noc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_rr_arbiter
// Purpose  : Round-robin arbiter. The search starts at the pointer; after an
//            accepted grant the pointer moves to the VC after the winner.
// Ports    : noc_clk, noc_rst_n (async active-low), i_clear (sync pointer
//            reset), i_req (request vector), i_update (advance pointer),
//            o_grant (one-hot), o_grant_idx (binary), o_any (any grant)
// Revision : 1.0 - initial release
// ============================================================================
module noc_rr_arbiter
    import noc_vc_credit_buffer_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = noc_vc_width(N)
) (
    input  logic             noc_clk,
    input  logic             noc_rst_n,
    input  logic             i_clear,
    input  logic [N-1:0]     i_req,
    input  logic             i_update,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_next_ptr;
    int               w_k;

    // Scan N positions starting at the pointer; the first request wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_k         = 0;
        for (int i = 0; i < N; i++) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= N) begin
                w_k = w_k - N;
            end
            if (!o_any && i_req[w_k]) begin
                o_any       = 1'b1;
                o_grant[w_k] = 1'b1;
                o_grant_idx = IDX_W'(w_k);
            end
        end
    end

    assign w_next_ptr = (o_grant_idx == IDX_W'(N - 1)) ? '0 : o_grant_idx + 1'b1;

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_ptr <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
        end else if (i_update && o_any) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_vc_credit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : noc_vc_credit_buffer
// Purpose  : Per-VC input FIFOs with credit flow control on both links. One
//            flit per cycle is forwarded, round-robin among VCs that hold
//            both data and downstream credit; each pop returns one credit
//            upstream.
// Ports    : noc_clk, noc_rst_n (async active-low), i_clear (sync flush)
//            input link : i_valid, i_vc, i_flit; o_credit (to upstream)
//            output link: o_valid, o_vc, o_flit (registered); i_credit
//            status     : o_empty, o_full, o_overflow, o_credit_err
// Revision : 1.0 - initial release
// ============================================================================
module noc_vc_credit_buffer
    import noc_vc_credit_buffer_pkg::*;
#(
    parameter int CHANNELS   = Noc_VC_Channel,
    parameter int DEPTH      = 8,
    parameter int CREDITS    = 8,
    parameter int FLIT_WIDTH = Noc_Data_Width,
    parameter int VC_W       = noc_vc_width(CHANNELS)
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [VC_W-1:0]       i_vc,
    input  logic [FLIT_WIDTH-1:0] i_flit,
    output logic [CHANNELS-1:0]   o_credit,
    output logic                  o_valid,
    output logic [VC_W-1:0]       o_vc,
    output logic [FLIT_WIDTH-1:0] o_flit,
    input  logic [CHANNELS-1:0]   i_credit,
    output logic [CHANNELS-1:0]   o_empty,
    output logic [CHANNELS-1:0]   o_full,
    output logic                  o_overflow,
    output logic                  o_credit_err
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_PTR_W  = c_ADDR_W + 1;
    localparam int c_CRED_W = $clog2(CREDITS + 1);
    localparam logic [c_CRED_W-1:0] c_CREDIT_INIT = c_CRED_W'(CREDITS);

    logic [CHANNELS-1:0]   w_empty;
    logic [CHANNELS-1:0]   w_full;
    logic [CHANNELS-1:0]   w_req;
    logic [CHANNELS-1:0]   w_gnt;
    logic [CHANNELS-1:0]   w_pop;
    logic [CHANNELS-1:0]   w_push;
    logic [CHANNELS-1:0]   w_cerr_set;
    logic [VC_W-1:0]       w_gnt_idx;
    logic                  w_any;
    logic                  w_vc_in_range;
    logic                  w_push_ok;
    logic                  w_drop;
    logic [FLIT_WIDTH-1:0] w_head [CHANNELS];

    logic                  r_valid;
    logic [VC_W-1:0]       r_vc;
    logic [FLIT_WIDTH-1:0] r_flit;
    logic                  r_overflow;
    logic                  r_credit_err;

    // A full VC still accepts a push when it is being popped the same cycle.
    assign w_vc_in_range = (32'(i_vc) < CHANNELS);
    assign w_push_ok     = i_valid && w_vc_in_range && (!w_full[i_vc] || w_pop[i_vc]);
    assign w_drop        = i_valid && !w_push_ok;

    noc_rr_arbiter #(
        .N     (CHANNELS),
        .IDX_W (VC_W)
    ) u_arb (
        .noc_clk     (noc_clk),
        .noc_rst_n   (noc_rst_n),
        .i_clear     (i_clear),
        .i_req       (w_req),
        .i_update    (!i_clear),
        .o_grant     (w_gnt),
        .o_grant_idx (w_gnt_idx),
        .o_any       (w_any)
    );

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        logic [c_PTR_W-1:0]    r_wr_ptr;
        logic [c_PTR_W-1:0]    r_rd_ptr;
        logic [c_CRED_W-1:0]   r_credit;
        logic [FLIT_WIDTH-1:0] r_mem [DEPTH];

        assign w_empty[v] = (r_wr_ptr == r_rd_ptr);
        assign w_full[v]  = (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]) &&
                            (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]);
        assign w_req[v]   = !w_empty[v] && (r_credit != '0);
        // A flush discards everything, so nothing is popped or credited.
        assign w_pop[v]   = w_gnt[v] && !i_clear;
        assign w_push[v]  = w_push_ok && (i_vc == VC_W'(v)) && !i_clear;
        assign w_head[v]  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
        // A concurrent grant cancels the returned credit, so only an
        // unmatched return at the ceiling is an error.
        assign w_cerr_set[v] = i_credit[v] && !w_pop[v] && (r_credit == c_CREDIT_INIT);

        always_ff @(posedge noc_clk or negedge noc_rst_n) begin
            if (!noc_rst_n) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_credit <= c_CREDIT_INIT;
            end else if (i_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_credit <= c_CREDIT_INIT;
            end else begin
                if (w_push[v]) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[v]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({i_credit[v], w_pop[v]})
                    2'b10: begin
                        if (r_credit != c_CREDIT_INIT) begin
                            r_credit <= r_credit + 1'b1;
                        end
                    end
                    2'b01:   r_credit <= r_credit - 1'b1;
                    default: r_credit <= r_credit;
                endcase
            end
        end

        always_ff @(posedge noc_clk) begin
            if (w_push[v]) begin
                r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_flit;
            end
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            r_valid      <= 1'b0;
            r_vc         <= '0;
            r_flit       <= '0;
            r_overflow   <= 1'b0;
            r_credit_err <= 1'b0;
        end else if (i_clear) begin
            r_valid      <= 1'b0;
            r_vc         <= '0;
            r_flit       <= '0;
            r_overflow   <= 1'b0;
            r_credit_err <= 1'b0;
        end else begin
            r_valid <= w_any;
            if (w_any) begin
                r_vc   <= w_gnt_idx;
                r_flit <= w_head[w_gnt_idx];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (|w_cerr_set) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    assign o_credit     = w_pop;
    assign o_valid      = r_valid;
    assign o_vc         = r_vc;
    assign o_flit       = r_flit;
    assign o_empty      = w_empty;
    assign o_full       = w_full;
    assign o_overflow   = r_overflow;
    assign o_credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_vc_credit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_vc_credit_buffer
// Purpose  : Directed self-checking bench for noc_vc_credit_buffer with
//            CHANNELS=2, DEPTH=8, CREDITS=2, FLIT_WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_vc_credit_buffer;

    logic       clk;
    logic       rst_n;
    logic       i_clear;
    logic       i_valid;
    logic [0:0] i_vc;
    logic [7:0] i_flit;
    logic [1:0] o_credit;
    logic       o_valid;
    logic [0:0] o_vc;
    logic [7:0] o_flit;
    logic [1:0] i_credit;
    logic [1:0] o_empty;
    logic [1:0] o_full;
    logic       o_overflow;
    logic       o_credit_err;

    int errors = 0;
    int checks = 0;

    noc_vc_credit_buffer #(
        .CHANNELS   (2),
        .DEPTH      (8),
        .CREDITS    (2),
        .FLIT_WIDTH (8)
    ) dut (
        .noc_clk      (clk),
        .noc_rst_n    (rst_n),
        .i_clear      (i_clear),
        .i_valid      (i_valid),
        .i_vc         (i_vc),
        .i_flit       (i_flit),
        .o_credit     (o_credit),
        .o_valid      (o_valid),
        .o_vc         (o_vc),
        .o_flit       (o_flit),
        .i_credit     (i_credit),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_overflow   (o_overflow),
        .o_credit_err (o_credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input logic vc, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_vc    = vc;
            i_flit  = base + 8'(i);
            step();
        end
        i_valid = 1'b0;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        checks++; if (o_credit !== 2'b00) begin errors++; $display("FAIL reset_credit: got %b want 00", o_credit); end
        checks++; if (o_empty !== 2'b11) begin errors++; $display("FAIL reset_empty: got %b want 11", o_empty); end
        checks++; if (o_full !== 2'b00) begin errors++; $display("FAIL reset_full: got %b want 00", o_full); end
        checks++; if ({o_overflow, o_credit_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {o_overflow, o_credit_err}); end
        checks++; if ({o_vc, o_flit} !== 9'h000) begin errors++; $display("FAIL reset_out: got %h want 000", {o_vc, o_flit}); end
    endtask

    task automatic test_latency();
        i_valid = 1'b1; i_vc = 1'b1; i_flit = 8'hA5;
        step();
        i_valid = 1'b0;
        checks++; if (o_credit !== 2'b10) begin errors++; $display("FAIL lat_credit_c1: got %b want 10", o_credit); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_c1: got %b want 0", o_valid); end
        step();
        checks++; if ({o_valid, o_vc, o_flit} !== {1'b1, 1'b1, 8'hA5}) begin errors++; $display("FAIL lat_out_c2: got %b/%b/%h want 1/1/a5", o_valid, o_vc, o_flit); end
        checks++; if (o_credit !== 2'b00) begin errors++; $display("FAIL lat_credit_c2: got %b want 00", o_credit); end
        i_credit = 2'b10;
        step();
        i_credit = 2'b00;
        step();
        checks++; if (o_credit_err !== 1'b0) begin errors++; $display("FAIL lat_cerr: got %b want 0", o_credit_err); end
    endtask

    task automatic test_back_to_back();
        int n_valid = 0;
        int first   = -1;
        int last    = -1;
        int pulses  = 0;
        for (int k = 0; k < 14; k++) begin
            i_valid  = (k < 8);
            i_vc     = 1'(k % 2);
            i_flit   = 8'h10 + 8'(k);
            // Downstream sink returns one credit for every flit it receives.
            i_credit = o_valid ? (2'b01 << o_vc) : 2'b00;
            pulses += $countones(o_credit);
            if (o_valid) begin
                checks++;
                if ({o_vc, o_flit} !== {1'(n_valid % 2), 8'h10 + 8'(n_valid)}) begin
                    errors++;
                    $display("FAIL b2b_flit%0d: got vc%0d/%h want vc%0d/%h", n_valid, o_vc, o_flit, n_valid % 2, 8'h10 + 8'(n_valid));
                end
                if (first < 0) first = k;
                last = k;
                n_valid++;
            end
            step();
        end
        i_valid  = 1'b0;
        i_credit = 2'b00;
        checks++; if (n_valid !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", n_valid); end
        checks++; if (last - first !== 7) begin errors++; $display("FAIL b2b_consecutive: got span %0d want 7", last - first); end
        checks++; if (pulses !== 8) begin errors++; $display("FAIL b2b_credit_pulses: got %0d want 8", pulses); end
        step();
    endtask

    task automatic test_credit_stall();
        int n_out = 0;
        for (int k = 0; k < 12; k++) begin
            i_valid = (k < 5);
            i_vc    = 1'b0;
            i_flit  = 8'h20 + 8'(k);
            if (o_valid) n_out++;
            step();
        end
        i_valid = 1'b0;
        checks++; if (n_out !== 2) begin errors++; $display("FAIL stall_out: got %0d want 2", n_out); end
        checks++; if (o_empty[0] !== 1'b0) begin errors++; $display("FAIL stall_held: got empty %b want 0", o_empty[0]); end
        i_credit = 2'b01;
        step();
        i_credit = 2'b00;
        n_out = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (o_valid) begin
                n_out++;
                checks++; if (o_flit !== 8'h22) begin errors++; $display("FAIL stall_resume_flit: got %h want 22", o_flit); end
            end
        end
        checks++; if (n_out !== 1) begin errors++; $display("FAIL stall_resume: got %0d want 1", n_out); end
    endtask

    // Leaves VC0 with its credit exhausted and an empty FIFO.
    task automatic drain_vc0_credit();
        do_clear();
        push_n(1'b0, 2, 8'h30);
        repeat (4) step();
    endtask

    task automatic test_overflow();
        drain_vc0_credit();
        push_n(1'b0, 8, 8'h40);
        checks++; if (o_full !== 2'b01) begin errors++; $display("FAIL ovf_full8: got %b want 01", o_full); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", o_overflow); end
        push_n(1'b0, 1, 8'h48);
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
        checks++; if ({o_full, o_empty[1]} !== 3'b011) begin errors++; $display("FAIL ovf_other_vc: got %b want 011", {o_full, o_empty[1]}); end
        push_n(1'b1, 1, 8'h55);
        step();
        checks++; if ({o_valid, o_vc, o_flit} !== {1'b1, 1'b1, 8'h55}) begin errors++; $display("FAIL ovf_vc1_flows: got %b/%b/%h want 1/1/55", o_valid, o_vc, o_flit); end
    endtask

    task automatic test_push_pop_full();
        drain_vc0_credit();
        push_n(1'b0, 8, 8'h60);
        checks++; if ({o_full[0], o_overflow} !== 2'b10) begin errors++; $display("FAIL pp_setup: got %b want 10", {o_full[0], o_overflow}); end
        i_credit = 2'b01;
        step();
        i_credit = 2'b00;
        i_valid  = 1'b1; i_vc = 1'b0; i_flit = 8'h77;
        checks++; if (o_credit !== 2'b01) begin errors++; $display("FAIL pp_pop: got %b want 01", o_credit); end
        step();
        i_valid = 1'b0;
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b want 0", o_overflow); end
        checks++; if (o_full[0] !== 1'b1) begin errors++; $display("FAIL pp_full: got %b want 1", o_full[0]); end
        checks++; if ({o_valid, o_flit} !== {1'b1, 8'h60}) begin errors++; $display("FAIL pp_out: got %b/%h want 1/60", o_valid, o_flit); end
    endtask

    task automatic test_credit_err_clear();
        i_credit = 2'b10;
        step();
        i_credit = 2'b00;
        checks++; if (o_credit_err !== 1'b1) begin errors++; $display("FAIL cerr_set: got %b want 1", o_credit_err); end
        push_n(1'b1, 1, 8'h88);
        i_clear = 1'b1;
        #1;
        checks++; if (o_credit !== 2'b00) begin errors++; $display("FAIL clr_no_pulse: got %b want 00", o_credit); end
        step();
        i_clear = 1'b0;
        checks++; if ({o_overflow, o_credit_err, o_valid} !== 3'b000) begin errors++; $display("FAIL clr_flags: got %b want 000", {o_overflow, o_credit_err, o_valid}); end
        checks++; if ({o_empty, o_full, o_credit} !== 6'b110000) begin errors++; $display("FAIL clr_fifo: got %b want 110000", {o_empty, o_full, o_credit}); end
        // VC0 had zero credit before the flush; a return now must saturate.
        i_credit = 2'b01;
        step();
        i_credit = 2'b00;
        checks++; if (o_credit_err !== 1'b1) begin errors++; $display("FAIL clr_counter_reset: got %b want 1", o_credit_err); end
    endtask

    initial begin
        rst_n    = 1'b0;
        i_clear  = 1'b0;
        i_valid  = 1'b0;
        i_vc     = 1'b0;
        i_flit   = 8'h00;
        i_credit = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        step();
        test_reset();
        test_latency();
        test_back_to_back();
        test_credit_stall();
        test_overflow();
        test_push_pop_full();
        test_credit_err_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_vc_credit_buffer.md
Name: noc_vc_credit_buffer

Overview:
Per-virtual-channel input buffer with credit-based flow control on both sides, replacing ready/valid backpressure on router-to-router links. Incoming flits carry a VC id and are stored in one circular FIFO per VC. A round-robin arbiter forwards one flit per cycle to a single output link, but only from VCs that hold downstream credit. Every dequeue returns one credit to the upstream sender.

Parameters:
CHANNELS, Noc_VC_Channel, number of VCs (>=1)
DEPTH, 8, entries per VC FIFO (power of two, >=2)
CREDITS, 8, downstream buffer depth per VC = initial credit count (>=1)
FLIT_WIDTH, Noc_Data_Width, flit payload width
VC_W, (CHANNELS>1)?$clog2(CHANNELS):1, VC id width (derived)

Ports:
noc_clk  in  1  clock
noc_rst_n  in  1  asynchronous active-low reset
i_clear  in  1  synchronous flush
i_valid  in  1  flit present on input link
i_vc  in  VC_W  VC of input flit
i_flit  in  FLIT_WIDTH  input flit
o_credit  out  CHANNELS  one-cycle pulse per VC: one slot freed, to upstream
o_valid  out  1  flit present on output link (registered)
o_vc  out  VC_W  VC of output flit (registered)
o_flit  out  FLIT_WIDTH  output flit (registered)
i_credit  in  CHANNELS  credit return from downstream, one per pulse per VC
o_empty  out  CHANNELS  per-VC FIFO empty
o_full  out  CHANNELS  per-VC FIFO full
o_overflow  out  1  sticky: push to a full VC was dropped
o_credit_err  out  1  sticky: credit returned while the counter was already at CREDITS

Behaviour:
- Clock/reset: one clock, noc_clk. Reset noc_rst_n is asynchronous and active-low.
- Reset values: all FIFOs empty; credit counters = CREDITS; RR pointer = VC0. Outputs: o_valid=0, o_vc=0, o_flit=0, o_credit=0, o_overflow=0, o_credit_err=0, o_empty=all 1, o_full=0.
- i_clear: same as reset but synchronous, and it overrides every other event in that cycle. Discarded flits produce no o_credit pulses.
- Push: when i_valid=1, i_flit is written to FIFO[i_vc]. It becomes eligible the next cycle.
- Push to a full VC that is not popped in the same cycle: the flit is dropped and o_overflow is set (sticky).
- Push to a full VC that is popped in the same cycle: the push is accepted and the count is unchanged.
- i_vc >= CHANNELS: the flit is dropped and o_overflow is set.
- Eligibility: VC v is eligible when FIFO[v] is non-empty and credit[v] > 0.
- Arbitration: round-robin among eligible VCs, starting the search at the pointer. At most one grant per cycle.
- On a grant to VC g:
  - pop FIFO[g];
  - decrement credit[g];
  - pulse o_credit[g] in the same cycle as the pop;
  - register the flit, so o_valid/o_vc/o_flit show it on the next cycle;
  - set the pointer to (g+1) mod CHANNELS.
- No grant: o_valid=0 next cycle, pointer unchanged.
- Latency: push at cycle t into an empty VC with credit gives o_valid at t+2. Sustained throughput is 1 flit/cycle across VCs.
- Credit counters: range 0..CREDITS, width $clog2(CREDITS+1).
  - i_credit[v] increments credit[v].
  - A same-cycle grant and i_credit on v leaves credit[v] unchanged.
  - i_credit[v] while credit[v]==CREDITS with no grant: counter saturates and o_credit_err is set (sticky).
- Credit = 0 on a VC: that VC stalls and holds its flits. Other VCs continue.
- FIFO pointers: $clog2(DEPTH)+1 bits each, with wrap bit. empty = pointers equal; full = addresses equal and wrap bits differ.
- o_empty and o_full are combinational from the pointers.
- The output link has no ready signal. The downstream is guaranteed to sink every flit sent under credit.

Decomposition:
- Noc_parameters package gains a typedef noc_vc_flit_t (packed: vc, flit) and a function noc_vc_width(CHANNELS).
- Sub-module noc_rr_arbiter:
  - parameter N;
  - inputs: request vector, pointer update enable;
  - outputs: one-hot grant, binary grant index, any-grant;
  - internal pointer register, async active-low reset on noc_clk/noc_rst_n.
- Per-VC FIFOs are storage arrays inside this block, generated per VC.

Test Plan:
- Reset, then push 1 flit on VC1 (data 0xA5) at cycle 0 -> o_valid=1, o_vc=1, o_flit=0xA5 at cycle 2; o_credit=2'b10 pulse at cycle 1.
- CHANNELS=2: push 4 flits to each VC back-to-back, full credit -> output order VC0,VC1,VC0,VC1..., 8 consecutive o_valid cycles, 8 o_credit pulses.
- CREDITS=2, no i_credit, push 5 flits to VC0 -> exactly 2 flits out, VC0 stalls with 3 held; pulse i_credit[0] once -> exactly 1 more flit out.
- DEPTH=8, credit held at 0, push 9 flits to VC0 -> o_full[0]=1 after 8 pushes, 9th push dropped, o_overflow=1; other VCs unaffected.
- Full VC0 with credit available, push VC0 in the same cycle as its pop -> push accepted, o_overflow stays 0, o_full[0] stays 1.
- i_credit[0] pulsed with credit[0]==CREDITS -> o_credit_err=1; then i_clear -> all flags 0, o_empty all 1, counters back to CREDITS, no o_credit pulses.
